// File: rtl/kr580_ports.sv
// KR580 I/O port bank: NPORTS write latches with write strobes, a registered
// read-back mux, and a frame-interrupt generator behind a control port.
module kr580_ports #(
  parameter int          WIDTH      = 8,
  parameter int          NPORTS     = 3,
  parameter logic [7:0]  PORT_BASE  = 8'hFC,
  parameter logic [7:0]  CTRL_ADDR  = 8'hFF,
  parameter int          INT_PERIOD = 500000,
  parameter int          INT_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               pin_pa,
  input  logic [WIDTH-1:0]         pin_po,
  input  logic                     pin_pw,
  output logic [WIDTH-1:0]         pin_pi,
  input  logic [NPORTS*WIDTH-1:0]  in_data,
  output logic [NPORTS*WIDTH-1:0]  port_q,
  output logic [NPORTS-1:0]        wr_stb,
  output logic                     pin_intr
);

  localparam int TW = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;
  localparam int WW = (INT_WIDTH > 0) ? $clog2(INT_WIDTH + 1) : 1;
  localparam logic [TW-1:0] TC    = TW'(INT_PERIOD - 1);
  localparam logic [WW-1:0] WLOAD = WW'(INT_WIDTH);

  logic [NPORTS-1:0]       hit, wrHit, stbHist_q;
  logic                    chit, ctrlWr, tc;
  logic [NPORTS*WIDTH-1:0] port_d;
  logic [WIDTH-1:0]        pi_d;
  logic                    ie_q, ie_d, pending_q, pending_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [WW-1:0]           wcnt_q, wcnt_d;

  always_comb begin
    hit    = '0;
    port_d = port_q;
    pi_d   = '1;
    for (int k = 0; k < NPORTS; k++) begin
      hit[k] = (pin_pa == 8'(int'(PORT_BASE) + k));
      if (pin_pw && hit[k]) port_d[k*WIDTH +: WIDTH] = pin_po;
      if (hit[k]) pi_d = in_data[k*WIDTH +: WIDTH];
    end
    chit   = (pin_pa == CTRL_ADDR);
    ctrlWr = pin_pw && chit;
    wrHit  = hit & {NPORTS{pin_pw}};
    if (chit) begin
      pi_d      = '0;
      pi_d[1:0] = {pending_q, ie_q};
    end
  end

  // A timer set on the same edge wins over both software and auto clear.
  always_comb begin
    tc        = (timer_q == TC);
    timer_d   = tc ? '0 : timer_q + 1'b1;
    ie_d      = ctrlWr ? pin_po[0] : ie_q;
    pending_d = pending_q;
    wcnt_d    = wcnt_q;
    if (tc && ie_q) begin
      pending_d = 1'b1;
      wcnt_d    = WLOAD;
    end else if (pending_q) begin
      if (ctrlWr && pin_po[1]) begin
        pending_d = 1'b0;
        wcnt_d    = '0;
      end else if (INT_WIDTH != 0) begin
        wcnt_d = wcnt_q - 1'b1;
        if (wcnt_q == WW'(1)) pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port_q    <= '0;
      wr_stb    <= '0;
      stbHist_q <= '0;
      pin_pi    <= '1;
      ie_q      <= 1'b0;
      pending_q <= 1'b0;
      timer_q   <= '0;
      wcnt_q    <= '0;
    end else begin
      port_q    <= port_d;
      wr_stb    <= wrHit & ~stbHist_q;
      stbHist_q <= wrHit;
      pin_pi    <= pi_d;
      ie_q      <= ie_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      wcnt_q    <= wcnt_d;
    end
  end

  assign pin_intr = pending_q;

endmodule

// File: tb/tb_kr580_ports.sv
// Scoreboard bench for kr580_ports: a default-shaped bank (A) with a short
// interrupt period and a 5x4-bit bank (B) with software-only interrupt clear.
module tb_kr580_ports;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  paA, poA, piA;
  logic        pwA, intrA;
  logic [23:0] inA, portA;
  logic [2:0]  stbA;
  logic [7:0]  paB;
  logic [3:0]  poB, piB;
  logic        pwB, intrB;
  logic [19:0] inB, portB;
  logic [4:0]  stbB;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } expT;

  expT sbQ[$];
  int  compared = 0;
  int  mismatched = 0;
  int  cyc = 0;
  int  hc;
  logic [3:0] rdB [5] = '{4'h6, 4'h3, 4'hC, 4'h9, 4'h7};

  kr580_ports #(.WIDTH(8), .NPORTS(3), .PORT_BASE(8'hFC), .CTRL_ADDR(8'hFF),
                .INT_PERIOD(100), .INT_WIDTH(4)) dutA (
    .clk(clk), .reset_n(reset_n), .pin_pa(paA), .pin_po(poA), .pin_pw(pwA),
    .pin_pi(piA), .in_data(inA), .port_q(portA), .wr_stb(stbA), .pin_intr(intrA));

  kr580_ports #(.WIDTH(4), .NPORTS(5), .PORT_BASE(8'hF0), .CTRL_ADDR(8'hFF),
                .INT_PERIOD(40), .INT_WIDTH(0)) dutB (
    .clk(clk), .reset_n(reset_n), .pin_pa(paB), .pin_po(poB), .pin_pw(pwB),
    .pin_pi(piB), .in_data(inB), .port_q(portB), .wr_stb(stbB), .pin_intr(intrB));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulusA(input logic [7:0] pa, input logic [7:0] po, input logic pw);
    paA = pa; poA = po; pwA = pw;
  endtask

  task automatic applyStimulusB(input logic [7:0] pa, input logic [3:0] po, input logic pw);
    paB = pa; poB = po; pwB = pw;
  endtask

  task automatic expectVal(input string tag, input logic [63:0] exp);
    expT e;
    e.tag = tag;
    e.exp = exp;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [63:0] obs);
    expT e;
    compared++;
    if (sbQ.size() == 0) begin
      mismatched++;
      $error("[TB] FAIL scoreboard_empty: observed %h, nothing expected", obs);
    end else begin
      e = sbQ.pop_front();
      assert (obs === e.exp) else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulusA(8'h00, 8'h00, 1'b0);
    applyStimulusB(8'h00, 4'h0, 1'b0);
    inA = {8'h11, 8'hA5, 8'h22};
    inB = {4'h7, 4'h9, 4'hC, 4'h3, 4'h6};
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Busy ports, then asynchronous reset with a write still held on B.
    applyStimulusA(8'hFC, 8'h33, 1'b1);
    applyStimulusB(8'hF2, 4'hA, 1'b1);
    tick(); tick();
    expectVal("pre_portA", 64'h33);  checkOutput(portA);
    expectVal("pre_portB", 64'hA00); checkOutput(portB);
    reset_n = 1'b0;
    #1;
    expectVal("rst_portA", 64'h0);  checkOutput(portA);
    expectVal("rst_piA", 64'hFF);   checkOutput(piA);
    expectVal("rst_intrA", 64'h0);  checkOutput(intrA);
    expectVal("rst_stbA", 64'h0);   checkOutput(stbA);
    expectVal("rst_portB", 64'h0);  checkOutput(portB);
    expectVal("rst_piB", 64'hF);    checkOutput(piB);
    applyStimulusA(8'h00, 8'h00, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;

    tick();
    expectVal("held_stbB", 64'h04);  checkOutput(stbB);
    expectVal("held_portB", 64'hA00); checkOutput(portB);
    expectVal("idle_piA", 64'hFF);    checkOutput(piA);
    tick();
    expectVal("held_stbB_2", 64'h0);  checkOutput(stbB);
    applyStimulusB(8'h00, 4'h0, 1'b0);

    // Multi-cycle write to FE, then the address moves to FD mid-write.
    applyStimulusA(8'hFE, 8'h05, 1'b1);
    tick();
    expectVal("wr_portA_1", 64'h050000); checkOutput(portA);
    expectVal("wr_stbA_1", 64'h4);       checkOutput(stbA);
    applyStimulusA(8'hFE, 8'h07, 1'b1);
    tick();
    expectVal("wr_portA_2", 64'h070000); checkOutput(portA);
    expectVal("wr_stbA_2", 64'h0);       checkOutput(stbA);
    applyStimulusA(8'hFD, 8'h07, 1'b1);
    tick();
    expectVal("wr_stbA_addrchg", 64'h2);  checkOutput(stbA);
    expectVal("wr_portA_3", 64'h070700);  checkOutput(portA);
    applyStimulusA(8'hFD, 8'h07, 1'b0);
    tick();
    expectVal("wr_stbA_4", 64'h0);        checkOutput(stbA);
    expectVal("wr_portA_4", 64'h070700);  checkOutput(portA);

    // Read-back mux.
    tick();
    expectVal("rd_FD", 64'hA5); checkOutput(piA);
    applyStimulusA(8'h10, 8'h00, 1'b0);
    tick();
    expectVal("rd_10", 64'hFF); checkOutput(piA);
    applyStimulusA(8'hFC, 8'h00, 1'b0);
    tick();
    expectVal("rd_FC", 64'h22); checkOutput(piA);

    applyStimulusA(8'hFF, 8'h01, 1'b1);
    tick();
    expectVal("rd_ctrl_old", 64'h00); checkOutput(piA);
    applyStimulusA(8'hFF, 8'h00, 1'b0);
    tick();
    expectVal("rd_ctrl_ie", 64'h01); checkOutput(piA);

    // B: one write per port with the strobe following the address, F5 ignored.
    for (int k = 0; k < 5; k++) begin
      applyStimulusB(8'hF0 + 8'(k), 4'(k + 8), 1'b1);
      tick();
      expectVal($sformatf("stbB_%0d", k), 64'(1 << k)); checkOutput(stbB);
    end
    applyStimulusB(8'hF5, 4'hF, 1'b1);
    tick();
    expectVal("stbB_F5", 64'h0);        checkOutput(stbB);
    expectVal("portB_all", 64'hCBA98);  checkOutput(portB);
    for (int k = 0; k < 5; k++) begin
      applyStimulusB(8'hF0 + 8'(k), 4'h0, 1'b0);
      tick();
      expectVal($sformatf("rdB_%0d", k), 64'(rdB[k])); checkOutput(piB);
    end

    // A interrupt: first at cycle 100, 4 cycles wide, every 100 cycles.
    while (cyc < 99) tick();
    expectVal("intrA_early", 64'h0); checkOutput(intrA);
    tick();
    expectVal("intrA_rise1", 64'h1); checkOutput(intrA);
    hc = 0;
    for (int i = 0; i < 10; i++) begin
      if (intrA) hc++;
      tick();
    end
    expectVal("intrA_width", 64'd4); checkOutput(hc);
    while (cyc < 199) tick();
    expectVal("intrA_pre2", 64'h0); checkOutput(intrA);
    tick();
    expectVal("intrA_rise2", 64'h1); checkOutput(intrA);

    // Software clear on the terminal-count edge loses; ie clear keeps pending.
    while (cyc < 299) tick();
    applyStimulusA(8'hFF, 8'h03, 1'b1);
    tick();
    expectVal("intrA_tc_clear", 64'h1); checkOutput(intrA);
    applyStimulusA(8'hFF, 8'h00, 1'b1);
    tick();
    expectVal("intrA_ie_off", 64'h1); checkOutput(intrA);
    applyStimulusA(8'hFF, 8'h00, 1'b0);
    tick(); tick();
    expectVal("intrA_303", 64'h1); checkOutput(intrA);
    tick();
    expectVal("intrA_304", 64'h0); checkOutput(intrA);
    while (cyc < 401) tick();
    expectVal("intrA_disabled", 64'h0); checkOutput(intrA);
    expectVal("rd_ctrlA_off", 64'h00);  checkOutput(piA);

    // B interrupt without auto-clear.
    applyStimulusB(8'hFF, 4'h1, 1'b1);
    tick();
    applyStimulusB(8'hFF, 4'h0, 1'b0);
    for (int i = 0; i < 100 && !intrB; i++) tick();
    expectVal("intrB_rise", 64'h1);  checkOutput(intrB);
    expectVal("intrB_phase", 64'h0); checkOutput(cyc % 40);
    repeat (5) tick();
    expectVal("intrB_held", 64'h1); checkOutput(intrB);
    applyStimulusB(8'hFF, 4'h3, 1'b1);
    tick();
    expectVal("intrB_swclr", 64'h0); checkOutput(intrB);
    applyStimulusB(8'hFF, 4'h0, 1'b0);
    tick();
    expectVal("rd_ctrlB_ie", 64'h1); checkOutput(piB);

    while (cyc < 479) tick();
    applyStimulusB(8'hFF, 4'h3, 1'b1);
    tick();
    expectVal("intrB_tc_clear", 64'h1); checkOutput(intrB);
    applyStimulusB(8'hFF, 4'h0, 1'b1);
    tick();
    expectVal("intrB_ie_off", 64'h1); checkOutput(intrB);
    applyStimulusB(8'hFF, 4'h0, 1'b0);
    tick();
    expectVal("rd_ctrlB_pend", 64'h2); checkOutput(piB);
    applyStimulusB(8'hFF, 4'h2, 1'b1);
    tick();
    expectVal("intrB_clr2", 64'h0); checkOutput(intrB);
    applyStimulusB(8'hFF, 4'h0, 1'b0);
    while (cyc < 521) tick();
    expectVal("intrB_disabled", 64'h0); checkOutput(intrB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
